// File: rtl/ysyx_25020037_rd_sched.sv
// ysyx_25020037_rd_sched: two-master AXI4 read scheduler (IFU=m0, LSU=m1) onto one downstream read port.
// LSU has fixed priority, and an anti-starvation counter lets the IFU win. One burst is in flight at a time.
`default_nettype none

module ysyx_25020037_rd_sched #(
    parameter int STARVE_MAX = 8,
    parameter int AW         = 32,
    parameter int DW         = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_arvalid_i,
    output logic          m0_arready_o,
    input  logic [AW-1:0] m0_araddr_i,
    input  logic [3:0]    m0_arid_i,
    input  logic [7:0]    m0_arlen_i,
    input  logic [2:0]    m0_arsize_i,
    input  logic [1:0]    m0_arburst_i,
    output logic          m0_rvalid_o,
    input  logic          m0_rready_i,
    output logic [DW-1:0] m0_rdata_o,
    output logic [1:0]    m0_rresp_o,
    output logic [3:0]    m0_rid_o,
    output logic          m0_rlast_o,
    input  logic          m1_arvalid_i,
    output logic          m1_arready_o,
    input  logic [AW-1:0] m1_araddr_i,
    input  logic [3:0]    m1_arid_i,
    input  logic [7:0]    m1_arlen_i,
    input  logic [2:0]    m1_arsize_i,
    input  logic [1:0]    m1_arburst_i,
    output logic          m1_rvalid_o,
    input  logic          m1_rready_i,
    output logic [DW-1:0] m1_rdata_o,
    output logic [1:0]    m1_rresp_o,
    output logic [3:0]    m1_rid_o,
    output logic          m1_rlast_o,
    output logic          s_arvalid_o,
    input  logic          s_arready_i,
    output logic [AW-1:0] s_araddr_o,
    output logic [3:0]    s_arid_o,
    output logic [7:0]    s_arlen_o,
    output logic [2:0]    s_arsize_o,
    output logic [1:0]    s_arburst_o,
    input  logic          s_rvalid_i,
    output logic          s_rready_o,
    input  logic [DW-1:0] s_rdata_i,
    input  logic [1:0]    s_rresp_i,
    input  logic [3:0]    s_rid_i,
    input  logic          s_rlast_i,
    output logic          busy_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [7:0] C_STARVE_MAX = 8'(STARVE_MAX);

    logic [1:0] state_q, state_d;
    logic       grant_q, grant_d;
    logic [7:0] starve_q, starve_d;
    logic [8:0] beat_q, beat_d;
    logic [7:0] len_q, len_d;

    logic       w_sel;
    logic       w_ar_hs;
    logic       w_r_hs;
    logic       w_cnt_end;
    logic [1:0] w_rresp;

    // LSU wins a tie unless the IFU has been passed over STARVE_MAX times in a row.
    assign w_sel     = m1_arvalid_i && !(m0_arvalid_i && (starve_q == C_STARVE_MAX));
    assign w_ar_hs   = (state_q == S_ADDR) && s_arvalid_o && s_arready_i;
    assign w_r_hs    = (state_q == S_DATA) && s_rvalid_i && s_rready_o;
    assign w_cnt_end = (beat_q == {1'b0, len_q});
    // A burst that runs out of beats without RLAST is closed with SLVERR on its final beat.
    assign w_rresp   = (w_cnt_end && !s_rlast_i) ? 2'b10 : s_rresp_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            grant_q  <= 1'b0;
            starve_q <= 8'd0;
            beat_q   <= 9'd0;
            len_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            starve_q <= starve_d;
            beat_q   <= beat_d;
            len_q    <= len_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        starve_d = starve_q;
        beat_d   = beat_q;
        len_d    = len_q;
        case (state_q)
            S_IDLE: begin
                if (m0_arvalid_i || m1_arvalid_i) begin
                    state_d = S_ADDR;
                    grant_d = w_sel;
                    if (!w_sel) begin
                        starve_d = 8'd0;
                    end else if (m0_arvalid_i && (starve_q < C_STARVE_MAX)) begin
                        starve_d = starve_q + 8'd1;
                    end
                end
            end
            S_ADDR: begin
                if (w_ar_hs) begin
                    state_d = S_DATA;
                    len_d   = grant_q ? m1_arlen_i : m0_arlen_i;
                    beat_d  = 9'd0;
                end
            end
            S_DATA: begin
                if (w_r_hs) begin
                    beat_d = beat_q + 9'd1;
                    if (s_rlast_i || w_cnt_end) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        m0_arready_o = 1'b0;
        m1_arready_o = 1'b0;
        m0_rvalid_o  = 1'b0;
        m0_rdata_o   = '0;
        m0_rresp_o   = 2'b00;
        m0_rid_o     = 4'd0;
        m0_rlast_o   = 1'b0;
        m1_rvalid_o  = 1'b0;
        m1_rdata_o   = '0;
        m1_rresp_o   = 2'b00;
        m1_rid_o     = 4'd0;
        m1_rlast_o   = 1'b0;
        s_arvalid_o  = 1'b0;
        s_araddr_o   = '0;
        s_arid_o     = 4'd0;
        s_arlen_o    = 8'd0;
        s_arsize_o   = 3'd0;
        s_arburst_o  = 2'b00;
        s_rready_o   = 1'b0;
        busy_o       = (state_q != S_IDLE);
        case (state_q)
            S_ADDR: begin
                if (grant_q) begin
                    s_arvalid_o  = m1_arvalid_i;
                    s_araddr_o   = m1_araddr_i;
                    s_arid_o     = m1_arid_i;
                    s_arlen_o    = m1_arlen_i;
                    s_arsize_o   = m1_arsize_i;
                    s_arburst_o  = m1_arburst_i;
                    m1_arready_o = s_arready_i;
                end else begin
                    s_arvalid_o  = m0_arvalid_i;
                    s_araddr_o   = m0_araddr_i;
                    s_arid_o     = m0_arid_i;
                    s_arlen_o    = m0_arlen_i;
                    s_arsize_o   = m0_arsize_i;
                    s_arburst_o  = m0_arburst_i;
                    m0_arready_o = s_arready_i;
                end
            end
            S_DATA: begin
                if (grant_q) begin
                    s_rready_o  = m1_rready_i;
                    m1_rvalid_o = s_rvalid_i;
                    m1_rdata_o  = s_rdata_i;
                    m1_rresp_o  = w_rresp;
                    m1_rid_o    = s_rid_i;
                    m1_rlast_o  = s_rlast_i;
                end else begin
                    s_rready_o  = m0_rready_i;
                    m0_rvalid_o = s_rvalid_i;
                    m0_rdata_o  = s_rdata_i;
                    m0_rresp_o  = w_rresp;
                    m0_rid_o    = s_rid_i;
                    m0_rlast_o  = s_rlast_i;
                end
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire
